// File: rtl/spi_slave_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_slave_cmd_sequencer
//
// Command sequencer behind the SPI slave byte shifter. It collects an 8-byte
// big-endian header: a 4-byte address, a command byte, a 2-byte length and a
// dummy byte. It then performs one of the following:
//   cmd 0 : no operation, the remaining bytes are drained
//   cmd 1 : one 32-bit CSR write on the Usi bus (len must be 4)
//   cmd 2 : one 32-bit CSR read on the Usi bus (len must be 4); the read
//           data is returned to the shifter MSB byte first
//   cmd 3 : a PSRAM burst write on the Ufi bus (len 4..pMaxLen, multiple of 4)
// Any other command or length sets the sticky error flag and drains the frame.
// When chip select drops, the sequencer returns to idle on the next cycle and
// drops every strobe.
//
// Ports
//   iSysClk, iSysRst          clock, synchronous active-high reset
//   iCsActive                 SPI chip select (1 = selected, already synced)
//   iRxByte / iRxVd           received byte and its one-cycle valid strobe
//   oTxByte / iTxNext         byte to send on MISO, consumed strobe
//   oMUsiWd/Adrs/WEd/RdReq    CSR master write data, address, write, read req
//   iMUsiRd / iMUsiREd        CSR read data and its valid strobe
//   oMUsiMonopoly             this block owns the Usi master
//   oMUfiWd/Adrs/WEd/WVd      PSRAM write word, byte address, word strobe,
//                             burst-active qualifier
//   oErr                      sticky error, cleared at the next header start
// -----------------------------------------------------------------------------
module spi_slave_cmd_sequencer #(
    parameter int pBusAdrsBit = 16,
    parameter int pMaxLen     = 2048,
    parameter int pRdTimeout  = 255
) (
    input  logic                   iSysClk,
    input  logic                   iSysRst,
    input  logic                   iCsActive,
    input  logic [7:0]             iRxByte,
    input  logic                   iRxVd,
    output logic [7:0]             oTxByte,
    input  logic                   iTxNext,
    output logic [31:0]            oMUsiWd,
    output logic [pBusAdrsBit-1:0] oMUsiAdrs,
    output logic                   oMUsiWEd,
    output logic                   oMUsiRdReq,
    input  logic [31:0]            iMUsiRd,
    input  logic                   iMUsiREd,
    output logic                   oMUsiMonopoly,
    output logic [31:0]            oMUfiWd,
    output logic [31:0]            oMUfiAdrs,
    output logic                   oMUfiWEd,
    output logic                   oMUfiWVd,
    output logic                   oErr
);

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_HDR         = 4'd1,
        ST_DECODE      = 4'd2,
        ST_CSR_WR      = 4'd3,
        ST_CSR_WR_STB  = 4'd4,
        ST_CSR_RD_REQ  = 4'd5,
        ST_CSR_RD_WAIT = 4'd6,
        ST_CSR_RD_TX   = 4'd7,
        ST_UFI         = 4'd8,
        ST_UFI_LAST    = 4'd9,
        ST_DRAIN       = 4'd10
    } state_t;

    // Header legality check: command and length combination.
    function automatic logic hdr_valid(input logic [7:0] cmd, input logic [15:0] len);
        logic ok;
        ok = 1'b0;
        case (cmd)
            8'd0:       ok = 1'b1;
            8'd1, 8'd2: ok = (len == 16'd4);
            8'd3:       ok = (len >= 16'd4) && (len <= 16'(pMaxLen)) && (len[1:0] == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State that follows DECODE for a given header; illegal headers drain.
    function automatic state_t hdr_target(input logic [7:0] cmd, input logic [15:0] len);
        state_t tgt;
        tgt = ST_DRAIN;
        if (hdr_valid(cmd, len)) begin
            case (cmd)
                8'd1:    tgt = ST_CSR_WR;
                8'd2:    tgt = ST_CSR_RD_REQ;
                8'd3:    tgt = ST_UFI;
                default: tgt = ST_DRAIN;
            endcase
        end else begin
            tgt = ST_DRAIN;
        end
        return tgt;
    endfunction

    // Big-endian byte select: index 0 is bits [31:24].
    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t                 state_q, state_d;
    // Only the first 7 header bytes are kept; the dummy byte is never stored.
    logic [55:0]            hdr_q, hdr_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            len_q, len_d;
    logic [15:0]            timer_q, timer_d;
    logic [1:0]             tx_idx_q, tx_idx_d;
    logic [31:0]            word_q, word_d;
    logic [31:0]            rd_data_q, rd_data_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic [31:0]            usi_wd_q, usi_wd_d;
    logic [pBusAdrsBit-1:0] usi_adrs_q, usi_adrs_d;
    logic                   usi_wed_q, usi_wed_d;
    logic                   usi_rdreq_q, usi_rdreq_d;
    logic                   monopoly_q, monopoly_d;
    logic [31:0]            ufi_wd_q, ufi_wd_d;
    logic [31:0]            ufi_adrs_q, ufi_adrs_d;
    logic                   ufi_wed_q, ufi_wed_d;
    logic                   ufi_wvd_q, ufi_wvd_d;
    logic                   err_q, err_d;

    logic [31:0]            hdr_adrs_s;
    logic [7:0]             hdr_cmd_s;
    logic [15:0]            hdr_len_s;
    logic                   hdr_ok_s;
    state_t                 hdr_tgt_s;
    logic                   hdr_is_csr_s;
    logic [31:0]            word_shift_s;

    assign hdr_adrs_s   = hdr_q[55:24];
    assign hdr_cmd_s    = hdr_q[23:16];
    assign hdr_len_s    = hdr_q[15:0];
    assign hdr_ok_s     = hdr_valid(hdr_cmd_s, hdr_len_s);
    assign hdr_tgt_s    = hdr_target(hdr_cmd_s, hdr_len_s);
    assign hdr_is_csr_s = (hdr_tgt_s == ST_CSR_WR) || (hdr_tgt_s == ST_CSR_RD_REQ);
    assign word_shift_s = {word_q[23:0], iRxByte};

    // Next-state, counter and output-register computation.
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        timer_d     = timer_q;
        tx_idx_d    = tx_idx_q;
        word_d      = word_q;
        rd_data_d   = rd_data_q;
        usi_wd_d    = usi_wd_q;
        usi_adrs_d  = usi_adrs_q;
        ufi_wd_d    = ufi_wd_q;
        ufi_wed_d   = 1'b0;
        err_d       = err_q;
        // The burst address moves to the next word right after each pulse.
        if (ufi_wed_q) begin
            ufi_adrs_d = ufi_adrs_q + 32'd4;
        end else begin
            ufi_adrs_d = ufi_adrs_q;
        end

        if (!iCsActive) begin
            // Chip select gone: abandon whatever is in flight.
            state_d = ST_IDLE;
            if ((state_q != ST_IDLE) && (state_q != ST_DRAIN)) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iRxVd) begin
                        hdr_d   = {48'd0, iRxByte};
                        cnt_d   = 16'd1;
                        err_d   = 1'b0;
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HDR: begin
                    if (iRxVd) begin
                        if (cnt_q == 16'd7) begin
                            // 8th byte is the dummy: decode without storing it.
                            cnt_d   = 16'd0;
                            state_d = ST_DECODE;
                        end else begin
                            hdr_d = {hdr_q[47:0], iRxByte};
                            cnt_d = cnt_q + 16'd1;
                        end
                    end else begin
                        state_d = ST_HDR;
                    end
                end
                ST_DECODE: begin
                    state_d    = hdr_tgt_s;
                    len_d      = hdr_len_s;
                    cnt_d      = 16'd0;
                    timer_d    = 16'd0;
                    tx_idx_d   = 2'd0;
                    ufi_adrs_d = (hdr_tgt_s == ST_UFI) ? hdr_adrs_s : ufi_adrs_q;
                    usi_adrs_d = hdr_is_csr_s ? hdr_adrs_s[pBusAdrsBit-1:0] : usi_adrs_q;
                    if (!hdr_ok_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end
                ST_CSR_WR: begin
                    if (iRxVd) begin
                        word_d = word_shift_s;
                        if (cnt_q == 16'd3) begin
                            usi_wd_d = word_shift_s;
                            state_d  = ST_CSR_WR_STB;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end else begin
                        state_d = ST_CSR_WR;
                    end
                end
                ST_CSR_WR_STB: state_d = ST_DRAIN;
                ST_CSR_RD_REQ: begin
                    timer_d = 16'd0;
                    state_d = ST_CSR_RD_WAIT;
                end
                ST_CSR_RD_WAIT: begin
                    if (iMUsiREd) begin
                        rd_data_d = iMUsiRd;
                        state_d   = ST_CSR_RD_TX;
                    end else if (timer_q == 16'(pRdTimeout - 1)) begin
                        rd_data_d = 32'd0;
                        err_d     = 1'b1;
                        state_d   = ST_CSR_RD_TX;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                ST_CSR_RD_TX: begin
                    if (iTxNext) begin
                        if (tx_idx_q == 2'd3) begin
                            state_d = ST_DRAIN;
                        end else begin
                            tx_idx_d = tx_idx_q + 2'd1;
                        end
                    end else begin
                        state_d = ST_CSR_RD_TX;
                    end
                end
                ST_UFI: begin
                    if (iRxVd) begin
                        word_d = word_shift_s;
                        cnt_d  = cnt_q + 16'd1;
                        // Every 4th byte completes a word for the burst.
                        if (cnt_q[1:0] == 2'd3) begin
                            ufi_wd_d  = word_shift_s;
                            ufi_wed_d = 1'b1;
                        end else begin
                            ufi_wed_d = 1'b0;
                        end
                        if (cnt_q == (len_q - 16'd1)) begin
                            state_d = ST_UFI_LAST;
                        end else begin
                            state_d = ST_UFI;
                        end
                    end else begin
                        state_d = ST_UFI;
                    end
                end
                // One cycle that carries the final pulse with WVd still high.
                ST_UFI_LAST: state_d = ST_DRAIN;
                ST_DRAIN:    state_d = ST_DRAIN;
                default:     state_d = ST_IDLE;
            endcase
        end

        // Strobes and qualifiers are registered from the next state so they
        // line up exactly with the state that owns them.
        usi_wed_d   = (state_d == ST_CSR_WR_STB);
        usi_rdreq_d = (state_d == ST_CSR_RD_REQ);
        ufi_wvd_d   = (state_d == ST_UFI) || (state_d == ST_UFI_LAST);
        monopoly_d  = (state_d == ST_CSR_WR) || (state_d == ST_CSR_WR_STB) ||
                      (state_d == ST_CSR_RD_REQ) || (state_d == ST_CSR_RD_WAIT) ||
                      ((state_d == ST_DECODE) && hdr_is_csr_s);
        tx_byte_d   = (state_d == ST_CSR_RD_TX) ? be_byte(rd_data_d, tx_idx_d) : 8'h00;
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            state_q     <= ST_IDLE;
            hdr_q       <= 56'd0;
            cnt_q       <= 16'd0;
            len_q       <= 16'd0;
            timer_q     <= 16'd0;
            tx_idx_q    <= 2'd0;
            word_q      <= 32'd0;
            rd_data_q   <= 32'd0;
            tx_byte_q   <= 8'h00;
            usi_wd_q    <= 32'd0;
            usi_adrs_q  <= '0;
            usi_wed_q   <= 1'b0;
            usi_rdreq_q <= 1'b0;
            monopoly_q  <= 1'b0;
            ufi_wd_q    <= 32'd0;
            ufi_adrs_q  <= 32'd0;
            ufi_wed_q   <= 1'b0;
            ufi_wvd_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            timer_q     <= timer_d;
            tx_idx_q    <= tx_idx_d;
            word_q      <= word_d;
            rd_data_q   <= rd_data_d;
            tx_byte_q   <= tx_byte_d;
            usi_wd_q    <= usi_wd_d;
            usi_adrs_q  <= usi_adrs_d;
            usi_wed_q   <= usi_wed_d;
            usi_rdreq_q <= usi_rdreq_d;
            monopoly_q  <= monopoly_d;
            ufi_wd_q    <= ufi_wd_d;
            ufi_adrs_q  <= ufi_adrs_d;
            ufi_wed_q   <= ufi_wed_d;
            ufi_wvd_q   <= ufi_wvd_d;
            err_q       <= err_d;
        end
    end

    assign oTxByte       = tx_byte_q;
    assign oMUsiWd       = usi_wd_q;
    assign oMUsiAdrs     = usi_adrs_q;
    assign oMUsiWEd      = usi_wed_q;
    assign oMUsiRdReq    = usi_rdreq_q;
    assign oMUsiMonopoly = monopoly_q;
    assign oMUfiWd       = ufi_wd_q;
    assign oMUfiAdrs     = ufi_adrs_q;
    assign oMUfiWEd      = ufi_wed_q;
    assign oMUfiWVd      = ufi_wvd_q;
    assign oErr          = err_q;

endmodule

// File: tb/tb_spi_slave_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for spi_slave_cmd_sequencer. Transactions are described by their
// header fields and payload. The expected bus writes, read-back bytes and
// error flag are derived from the command rules. A negedge monitor collects
// every strobe the DUT issues so it can be compared with that expectation.
// -----------------------------------------------------------------------------
module tb_spi_slave_cmd_sequencer;

    logic        iSysClk = 1'b0;
    logic        iSysRst = 1'b1;
    logic        iCsActive = 1'b0;
    logic [7:0]  iRxByte = 8'h00;
    logic        iRxVd = 1'b0;
    logic        iTxNext = 1'b0;
    logic [31:0] iMUsiRd = 32'd0;
    logic        iMUsiREd = 1'b0;
    logic [7:0]  oTxByte;
    logic [31:0] oMUsiWd;
    logic [15:0] oMUsiAdrs;
    logic        oMUsiWEd, oMUsiRdReq, oMUsiMonopoly;
    logic [31:0] oMUfiWd, oMUfiAdrs;
    logic        oMUfiWEd, oMUfiWVd, oErr;

    spi_slave_cmd_sequencer dut (
        .iSysClk(iSysClk), .iSysRst(iSysRst), .iCsActive(iCsActive),
        .iRxByte(iRxByte), .iRxVd(iRxVd), .oTxByte(oTxByte), .iTxNext(iTxNext),
        .oMUsiWd(oMUsiWd), .oMUsiAdrs(oMUsiAdrs), .oMUsiWEd(oMUsiWEd),
        .oMUsiRdReq(oMUsiRdReq), .iMUsiRd(iMUsiRd), .iMUsiREd(iMUsiREd),
        .oMUsiMonopoly(oMUsiMonopoly), .oMUfiWd(oMUfiWd), .oMUfiAdrs(oMUfiAdrs),
        .oMUfiWEd(oMUfiWEd), .oMUfiWVd(oMUfiWVd), .oErr(oErr)
    );

    always #5 iSysClk = ~iSysClk;

    int errors = 0;
    int checks = 0;
    logic [63:0] got_ufi[$], exp_ufi[$], got_usi[$], exp_usi[$];
    logic [7:0]  dbuf[0:2047];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Collect every write strobe the DUT issues.
    always @(negedge iSysClk) begin
        if (oMUfiWEd === 1'b1) begin
            got_ufi.push_back({oMUfiAdrs, oMUfiWd});
            chk("ufi_wvd_at_pulse", 64'(oMUfiWVd), 64'd1);
        end
        if (oMUsiWEd === 1'b1) begin
            got_usi.push_back({16'd0, oMUsiAdrs, oMUsiWd});
            chk("usi_monopoly_at_pulse", 64'(oMUsiMonopoly), 64'd1);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge iSysClk);
        iRxByte = b;
        iRxVd   = 1'b1;
        @(negedge iSysClk);
        iRxVd   = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] a, input logic [7:0] cmd,
                            input logic [15:0] len, input int gapmax);
        logic [7:0] h[8];
        h[0] = a[31:24]; h[1] = a[23:16]; h[2] = a[15:8]; h[3] = a[7:0];
        h[4] = cmd; h[5] = len[15:8]; h[6] = len[7:0]; h[7] = 8'($urandom);
        for (int i = 0; i < 8; i++) send_byte(h[i], int'($urandom_range(gapmax, 0)));
    endtask

    // Release CS; a byte strobe while deselected must be ignored.
    task automatic end_txn();
        repeat (2) @(negedge iSysClk);
        iCsActive = 1'b0;
        iRxByte   = 8'h03;
        iRxVd     = 1'b1;
        @(negedge iSysClk);
        iRxVd     = 1'b0;
        @(negedge iSysClk);
    endtask

    task automatic compare_queues();
        chk("ufi_write_count", 64'(got_ufi.size()), 64'(exp_ufi.size()));
        for (int i = 0; i < got_ufi.size() && i < exp_ufi.size(); i++)
            chk("ufi_adrs_data", got_ufi[i], exp_ufi[i]);
        chk("usi_write_count", 64'(got_usi.size()), 64'(exp_usi.size()));
        for (int i = 0; i < got_usi.size() && i < exp_usi.size(); i++)
            chk("usi_adrs_data", got_usi[i], exp_usi[i]);
        got_ufi.delete(); exp_ufi.delete(); got_usi.delete(); exp_usi.delete();
    endtask

    // PSRAM burst of len bytes from dbuf; CS drops after 'sent' bytes if sent<len.
    task automatic txn_ufi(input logic [31:0] a, input int len, input int sent, input int gapmax);
        for (int i = 0; i < sent / 4; i++)
            exp_ufi.push_back({a + 32'(4 * i),
                               dbuf[4*i], dbuf[4*i+1], dbuf[4*i+2], dbuf[4*i+3]});
        iCsActive = 1'b1;
        send_hdr(a, 8'd3, 16'(len), gapmax);
        @(negedge iSysClk);
        for (int i = 0; i < sent; i++) send_byte(dbuf[i], int'($urandom_range(gapmax, 0)));
        if (sent == len) begin
            chk("ufi_last_pulse", 64'(oMUfiWEd), 64'd1);
            @(negedge iSysClk);
            chk("ufi_wvd_drop", 64'(oMUfiWVd), 64'd0);
            end_txn();
            chk("ufi_err", 64'(oErr), 64'd0);
        end else begin
            iCsActive = 1'b0;
            @(negedge iSysClk);
            chk("abort_wvd_low", 64'(oMUfiWVd), 64'd0);
            chk("abort_err", 64'(oErr), 64'd1);
            repeat (2) @(negedge iSysClk);
        end
        compare_queues();
    endtask

    task automatic txn_csr_wr(input logic [31:0] a, input logic [31:0] d, input int gapmax);
        exp_usi.push_back({16'd0, a[15:0], d});
        chk("wr_monopoly_idle", 64'(oMUsiMonopoly), 64'd0);
        iCsActive = 1'b1;
        send_hdr(a, 8'd1, 16'd4, gapmax);
        chk("wr_monopoly_decode", 64'(oMUsiMonopoly), 64'd1);
        @(negedge iSysClk);
        for (int i = 0; i < 4; i++)
            send_byte(d[8*(3-i) +: 8], int'($urandom_range(gapmax, 0)));
        chk("wr_strobe", 64'(oMUsiWEd), 64'd1);
        @(negedge iSysClk);
        chk("wr_monopoly_release", 64'(oMUsiMonopoly), 64'd0);
        end_txn();
        chk("wr_err", 64'(oErr), 64'd0);
        compare_queues();
    endtask

    // CSR read; lat>0 returns data lat cycles after the request, lat==0 never answers.
    task automatic txn_csr_rd(input logic [31:0] a, input logic [31:0] d, input int lat);
        logic [31:0] exp_d;
        logic        exp_err;
        logic        found;
        int          n;
        // A stray read-valid while idle must have no effect.
        @(negedge iSysClk);
        iMUsiRd = 32'hDEAD_BEEF; iMUsiREd = 1'b1;
        @(negedge iSysClk);
        iMUsiREd = 1'b0;
        iCsActive = 1'b1;
        send_hdr(a, 8'd2, 16'd4, 1);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge iSysClk);
            if (oMUsiRdReq === 1'b1) found = 1'b1;
        end
        chk("rd_req_seen", 64'(found), 64'd1);
        chk("rd_adrs", 64'(oMUsiAdrs), 64'(a[15:0]));
        chk("rd_monopoly_req", 64'(oMUsiMonopoly), 64'd1);
        if (lat > 0) begin
            repeat (lat) @(negedge iSysClk);
            iMUsiRd = d; iMUsiREd = 1'b1;
            @(negedge iSysClk);
            iMUsiREd = 1'b0;
            exp_d = d; exp_err = 1'b0;
        end else begin
            n = 0;
            while (oMUsiMonopoly === 1'b1 && n < 400) begin
                @(negedge iSysClk);
                n++;
            end
            chk("rd_timeout_window", 64'((n >= 255) && (n <= 257)), 64'd1);
            exp_d = 32'd0; exp_err = 1'b1;
        end
        chk("rd_monopoly_release", 64'(oMUsiMonopoly), 64'd0);
        chk("rd_err", 64'(oErr), 64'(exp_err));
        for (int k = 0; k < 4; k++) begin
            chk("rd_tx_byte", 64'(oTxByte), 64'(exp_d[8*(3-k) +: 8]));
            repeat ($urandom_range(2, 0)) @(negedge iSysClk);
            iTxNext = 1'b1;
            @(negedge iSysClk);
            iTxNext = 1'b0;
        end
        chk("rd_tx_after", 64'(oTxByte), 64'd0);
        end_txn();
        chk("rd_err_end", 64'(oErr), 64'(exp_err));
        compare_queues();
    endtask

    // Header that only drains (cmd 0) or is illegal; trailing bytes must not write.
    task automatic txn_drain(input logic [7:0] cmd, input logic [15:0] len, input logic exp_err);
        iCsActive = 1'b1;
        send_hdr(32'h0000_0100, cmd, len, 1);
        @(negedge iSysClk);
        chk("drain_err_decode", 64'(oErr), 64'(exp_err));
        for (int i = 0; i < 12; i++) send_byte(8'($urandom), 0);
        end_txn();
        chk("drain_err_end", 64'(oErr), 64'(exp_err));
        compare_queues();
    endtask

    task automatic txn_hdr_abort(input int nbytes);
        iCsActive = 1'b1;
        for (int i = 0; i < nbytes; i++) send_byte(8'($urandom), 0);
        iCsActive = 1'b0;
        @(negedge iSysClk);
        chk("hdr_abort_err", 64'(oErr), 64'd1);
        repeat (2) @(negedge iSysClk);
        compare_queues();
    endtask

    logic [15:0] bad_len;
    logic [31:0] ra;
    int          len, sent, kind;

    initial begin
        repeat (4) @(negedge iSysClk);
        chk("rst_tx", 64'(oTxByte), 64'd0);
        chk("rst_usi_wd", 64'(oMUsiWd), 64'd0);
        chk("rst_usi_adrs", 64'(oMUsiAdrs), 64'd0);
        chk("rst_usi_wed", 64'(oMUsiWEd), 64'd0);
        chk("rst_usi_rdreq", 64'(oMUsiRdReq), 64'd0);
        chk("rst_monopoly", 64'(oMUsiMonopoly), 64'd0);
        chk("rst_ufi_wd", 64'(oMUfiWd), 64'd0);
        chk("rst_ufi_adrs", 64'(oMUfiAdrs), 64'd0);
        chk("rst_ufi_wed", 64'(oMUfiWEd), 64'd0);
        chk("rst_ufi_wvd", 64'(oMUfiWVd), 64'd0);
        chk("rst_err", 64'(oErr), 64'd0);
        iSysRst = 1'b0;
        @(negedge iSysClk);

        txn_csr_wr(32'h0000_0008, 32'h1234_5678, 0);
        txn_csr_rd(32'h0000_0010, 32'hCAFE_F00D, 5);
        txn_csr_rd(32'h0000_0010, 32'hCAFE_F00D, 0);
        for (int i = 0; i < 16; i++) dbuf[i] = 8'(i);
        txn_ufi(32'h8765_0304, 16, 16, 0);
        txn_drain(8'd3, 16'h0006, 1'b1);
        txn_drain(8'd3, 16'h0804, 1'b1);
        txn_drain(8'd3, 16'h0000, 1'b1);
        txn_drain(8'd0, 16'h0010, 1'b0);
        for (int i = 0; i < 2048; i++) dbuf[i] = 8'($urandom);
        txn_ufi(32'h0000_2000, 8, 6, 0);
        txn_csr_wr(32'hABCD_1234, 32'h0BAD_F00D, 1);
        txn_ufi(32'hFFFF_FFF8, 16, 16, 1);
        txn_ufi(32'h0000_0040, 4, 4, 0);
        txn_ufi(32'h1000_0000, 2048, 2048, 0);

        // Reset in the middle of a burst: one word already written, then silence.
        exp_ufi.push_back({32'h0000_0800, dbuf[0], dbuf[1], dbuf[2], dbuf[3]});
        iCsActive = 1'b1;
        send_hdr(32'h0000_0800, 8'd3, 16'd16, 0);
        @(negedge iSysClk);
        for (int i = 0; i < 5; i++) send_byte(dbuf[i], 0);
        iSysRst = 1'b1;
        @(negedge iSysClk);
        chk("midrst_wvd", 64'(oMUfiWVd), 64'd0);
        chk("midrst_adrs", 64'(oMUfiAdrs), 64'd0);
        chk("midrst_err", 64'(oErr), 64'd0);
        iCsActive = 1'b0;
        iSysRst = 1'b0;
        repeat (2) @(negedge iSysClk);
        compare_queues();

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(6, 0));
            ra = $urandom;
            for (int i = 0; i < 64; i++) dbuf[i] = 8'($urandom);
            case (kind)
                0: begin
                    len = 4 * int'($urandom_range(16, 1));
                    txn_ufi(ra, len, len, 2);
                end
                1: begin
                    len  = 4 * int'($urandom_range(8, 2));
                    sent = int'($urandom_range(len - 1, 0));
                    txn_ufi(ra, len, sent, 1);
                end
                2: txn_csr_wr(ra, $urandom, 2);
                3: txn_csr_rd(ra, $urandom, int'($urandom_range(30, 1)));
                4: begin
                    bad_len = 16'($urandom_range(3000, 0));
                    if (bad_len == 16'd4) bad_len = 16'd5;
                    txn_drain(8'($urandom_range(2, 1)), bad_len, 1'b1);
                end
                5: begin
                    bad_len = 16'($urandom);
                    txn_drain(8'($urandom_range(255, 4)), bad_len, 1'b1);
                end
                default: txn_hdr_abort(int'($urandom_range(7, 1)));
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
